// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int BE_W       = ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } arb_state_t;

    // Request fields captured when a grant is issued; drive mem_* until ack.
    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [BE_W-1:0]       be;
    } arb_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, MEM-stage and memory-side signals of the shared port.
// Latency: n/a (wiring only).
// Backpressure: req held by requester until its single-cycle valid; stalls freeze the pipeline.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    // fetch requester
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_valid;
    logic [DATA_W-1:0]   if_rdata;
    // MEM-stage requester
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_be;
    logic                d_valid;
    logic [DATA_W-1:0]   d_rdata;
    // memory side
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    // pipeline control
    logic                stall_f;
    logic                stall_m;
    logic                busy;

    // arbiter view
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ack, mem_rdata,
        output if_valid, if_rdata, d_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output stall_f, stall_m, busy
    );

    // pipeline + memory view
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ack, mem_rdata,
        input  if_valid, if_rdata, d_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall_f, stall_m, busy
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts data grants taken while fetch waits; flags when fetch must win.
// Latency: hit reflects the registered count, usable in the same IDLE arbitration.
// Backpressure: none; inc/clr are single-cycle events from the arbiter.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clear wins over increment; saturate so the count never wraps back below STARVE_MAX
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(STARVE_MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and MEM stage, MEM stage first.
// Latency: request seen in IDLE at N, mem_req from N+1, valid with mem_ack (>= 2 cycles/access).
// Backpressure: requesters hold req until valid; stall_f/stall_m freeze the pipeline meanwhile.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state_q, state_d;
    arb_req_t   req_q, req_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       busy_q, busy_d;
    logic       pick_d, pick_i;
    logic       fetch_first;
    logic       d_vld, i_vld;

`ifdef ARB_STARVE_GUARD_EN
    logic starve_inc, starve_clr;

    assign starve_inc = pick_d && bus.if_req;
    assign starve_clr = pick_i || ((state_q == IDLE) && !bus.if_req);

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk (clk),
        .rst_n (rst_n),
        .inc (starve_inc),
        .clr (starve_clr),
        .hit (fetch_first)
    );
`else
    assign fetch_first = 1'b0;
`endif

    // arbitration is only evaluated in IDLE; data wins unless fetch has been starved
    always_comb begin
        pick_d = 1'b0;
        pick_i = 1'b0;
        if (state_q == IDLE) begin
            if (bus.d_req && !(bus.if_req && fetch_first)) begin
                pick_d = 1'b1;
            end else if (bus.if_req) begin
                pick_i = 1'b1;
            end
        end
    end

    // next state, request capture on the grant edge, and registered memory-side outputs
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d     = GNT_D;
                    req_d.we    = bus.d_we;
                    req_d.addr  = bus.d_addr;
                    req_d.wdata = bus.d_wdata;
                    req_d.be    = bus.d_be;
                end else if (pick_i) begin
                    state_d     = GNT_I;
                    req_d.we    = 1'b0;
                    req_d.addr  = bus.if_addr;
                    req_d.wdata = '0;
                    req_d.be    = '1;
                end
            end
            GNT_D, GNT_I: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_req_d = (state_d != IDLE);
        mem_we_d  = (state_d == GNT_D) && req_d.we;
        busy_d    = (state_d != IDLE);
    end

    // state and output registers; reset abandons any outstanding access immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            busy_q    <= busy_d;
        end
    end

    // an ack outside a grant state (e.g. late ack after reset) produces no valid
    assign d_vld = (state_q == GNT_D) && bus.mem_ack;
    assign i_vld = (state_q == GNT_I) && bus.mem_ack;

    assign bus.d_valid   = d_vld;
    assign bus.if_valid  = i_vld;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.if_rdata  = bus.mem_rdata;

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_be    = req_q.be;

    assign bus.stall_m   = bus.d_req && !d_vld;
    assign bus.stall_f   = (bus.if_req && !i_vld) || bus.stall_m;
    assign bus.busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the fetch stage (instruction reads) and the MEM stage (data loads/stores) of the 5-stage RV32I pipeline.
- Sequences each access with a request/acknowledge handshake.
- Drives the stall signals that freeze the PC/IF-ID registers (stall_f) and the EX-MEM/MEM-WB registers (stall_m) while an access is outstanding.
- MEM stage has priority by default, because it holds the older instruction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch read request; held until if_valid
- if_addr  in  ADDR_W  fetch address (PCF)
- if_valid  out  1  fetch data valid, single-cycle
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  MEM-stage request; held until d_valid
- d_we  in  1  1 = store (MemWriteM)
- d_addr  in  ADDR_W  ALUResultM
- d_wdata  in  DATA_W  WriteDataM
- d_be  in  DATA_W/8  byte enables
- d_valid  out  1  data access complete, single-cycle
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_ack  in  1  memory done, single-cycle; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- stall_f  out  1  freeze PC and IF-ID register
- stall_m  out  1  freeze EX-MEM and MEM-WB registers; bubble into WB
- busy  out  1  a grant is outstanding

Behaviour:
- FSM states: IDLE, GNT_D, GNT_I. The state register is reset asynchronously to IDLE.
- IDLE:
  - d_req=1 -> GNT_D; else if_req=1 -> GNT_I; else stay in IDLE.
  - Request fields (we, addr, wdata, be) are latched on the transition edge.
- GNT_D and GNT_I:
  - mem_req=1 and mem_* driven from the latched registers only; they stay stable until ack.
  - Remain in the state until mem_ack=1, then return to IDLE at that edge.
  - A new grant is not possible before the next IDLE cycle.
- Valid signals are combinational:
  - d_valid = (state==GNT_D) && mem_ack
  - if_valid = (state==GNT_I) && mem_ack
  - d_rdata and if_rdata pass mem_rdata through. Their value is don't-care when valid=0; for stores, d_rdata is don't-care.
- Stall signals:
  - stall_m = d_req && !d_valid
  - stall_f = (if_req && !if_valid) || stall_m
- Latency:
  - Request seen in IDLE at cycle N; mem_req at N+1; valid earliest at N+1 (zero-wait memory).
  - Minimum 2 cycles per access. Throughput is one access per 2 cycles.
- Requests arriving while the FSM is in a GNT state are not sampled. Requesters hold req until their valid pulse.
- Simultaneous d_req and if_req in IDLE: data wins (see Optional Feature).
- mem_ack while in IDLE is ignored, and no valid is generated.
- busy = (state != IDLE).
- Reset values: all outputs 0. The latched registers reset to 0.
- Reset asserted mid-transaction:
  - State returns to IDLE immediately and mem_req drops to 0 asynchronously.
  - The transaction is abandoned. The memory model must discard it, and a late mem_ack is ignored.
- Misaligned addresses pass through unchecked; alignment is the MEM stage's responsibility.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A counter (width $clog2(STARVE_MAX+1)) increments on each GNT_D entry taken while if_req=1.
  - It clears on GNT_I entry, or when if_req=0 in IDLE.
  - When the count equals STARVE_MAX, the next IDLE arbitration with both requests pending grants fetch.
  - The counter resets to 0.
- Not defined: strict data priority. The counter logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, GNT_D, GNT_I}
  - localparam BE_W = DATA_W/8
  - the request-field struct (we, addr, wdata, be)
- Optional sub-module arb_starve_ctr (the starvation counter) is instantiated only under ARB_STARVE_GUARD_EN. Everything else stays in a single module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_ack after 2 wait cycles with rdata=0x00500093.
  - Expect mem_req from cycle 1 to cycle 3, if_valid and if_rdata=0x00500093 on cycle 3, stall_f high on cycles 0-2.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=0xF, zero-wait ack.
  - Expect mem_we=1, mem_addr=0x2000 for one cycle, d_valid pulse, stall_m=1 then 0, stall_f=1 throughout.
- Simultaneous requests in IDLE, load at 0x2004 and fetch at 0x104.
  - Expect the load to be granted first and the fetch granted on the next IDLE.
  - Expect if_valid exactly 2 cycles after d_valid with zero-wait memory.
- ARB_STARVE_GUARD_EN with STARVE_MAX=4: d_req held continuously (5 back-to-back loads) with if_req pending.
  - Expect grant order D,D,D,D,I,D. Without the macro, expect all D grants before I.
- Reset mid-access: rst_n low during GNT_D with mem_ack withheld.
  - Expect mem_req=0 asynchronously and state=IDLE.
  - After release, an ack in IDLE produces no d_valid.
- Stable hold: toggle d_addr while in GNT_D before ack.
  - Expect mem_addr unchanged (latched value).
